// File: rtl/branch_target_predictor_pkg.sv
// Shared types, default sizes and counter helper for the
// branch target predictor.
package branch_target_predictor_pkg;

    localparam int ADDR_W       = 32;
    localparam int BP_WIDTH     = 2;
    localparam int BP_ENTRIES   = 64;
    localparam int BP_TAG_BITS  = 8;
    localparam int BP_HIST_BITS = 0;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        logic  valid;
        addr_t pc;
    } bp_lookup_packet_t;

    typedef struct packed {
        logic  valid;
        addr_t pc;
        logic  taken;
        logic  uncond;
        addr_t target;
    } bp_update_packet_t;

    function automatic logic [1:0] ctr_step(
        input logic [1:0] ctr,
        input logic       taken
    );
        logic [1:0] r;
        r = ctr;
        unique case (1'b1)
            taken && (ctr != 2'd3):  r = ctr + 2'd1;
            !taken && (ctr != 2'd0): r = ctr - 2'd1;
            default:                 r = ctr;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bp_index_hash.sv
// PC (+ optional global history) to BTB index and tag.
// Bimodal mode ignores the history input.
module bp_index_hash
    import branch_target_predictor_pkg::*;
#(
    parameter int IDX       = 6,
    parameter int TAG_BITS  = 8,
    parameter int HIST_BITS = 0,
    parameter int HW        = 1
) (
    input  addr_t               pc,
    input  logic [HW-1:0]       ghr,
    output logic [IDX-1:0]      idx,
    output logic [TAG_BITS-1:0] tag
);

    logic [IDX-1:0] base;
    logic           unused_bits;

    assign base        = pc[IDX+1:2];
    assign tag         = pc[IDX+1+TAG_BITS:IDX+2];
    assign unused_bits = ^{pc, ghr};

    generate
        if (HIST_BITS > 0) begin : g_gshare
            assign idx = base ^ IDX'(ghr);
        end else begin : g_bimodal
            assign idx = base;
        end
    endgenerate

endmodule

// File: rtl/branch_target_predictor.sv
// N-wide tagged BTB with 2-bit direction counters and
// optional gshare indexing; trained in order at commit.
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int WIDTH     = BP_WIDTH,
    parameter int ENTRIES   = BP_ENTRIES,
    parameter int TAG_BITS  = BP_TAG_BITS,
    parameter int HIST_BITS = BP_HIST_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      lookup_valid,
    input  addr_t [WIDTH-1:0]     lookup_pc,
    output logic [WIDTH-1:0]      pred_hit,
    output logic [WIDTH-1:0]      pred_taken,
    output addr_t [WIDTH-1:0]     pred_target,
    input  logic [WIDTH-1:0]      update_valid,
    input  addr_t [WIDTH-1:0]     update_pc,
    input  logic [WIDTH-1:0]      update_taken,
    input  logic [WIDTH-1:0]      update_uncond,
    input  addr_t [WIDTH-1:0]     update_target
);

    localparam int IDX = $clog2(ENTRIES);
    localparam int HW  = (HIST_BITS > 0) ? HIST_BITS : 1;

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        addr_t               target;
        logic                uncond;
        logic [1:0]          ctr;
    } bp_entry_t;

    bp_entry_t tbl_q [ENTRIES];
    bp_entry_t tbl_d [ENTRIES];

    logic [HW-1:0]       ghr_q;
    logic [HW-1:0]       ghr_next;
    logic [HW-1:0]       ghr_used [WIDTH];
    logic [IDX-1:0]      l_idx [WIDTH];
    logic [TAG_BITS-1:0] l_tag [WIDTH];
    logic [IDX-1:0]      u_idx [WIDTH];
    logic [TAG_BITS-1:0] u_tag [WIDTH];

    // Each update slot sees history already shifted by older slots.
    always_comb begin
        logic [HW-1:0] g;
        g = ghr_q;
        for (int i = 0; i < WIDTH; i++) begin
            ghr_used[i] = g;
            if (HIST_BITS > 0 && update_valid[i] && !update_uncond[i])
                g = (g << 1) | HW'(update_taken[i]);
        end
        ghr_next = g;
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_slot
            bp_index_hash #(
                .IDX(IDX), .TAG_BITS(TAG_BITS),
                .HIST_BITS(HIST_BITS), .HW(HW)
            ) u_lhash (
                .pc(lookup_pc[i]), .ghr(ghr_q),
                .idx(l_idx[i]), .tag(l_tag[i])
            );

            bp_index_hash #(
                .IDX(IDX), .TAG_BITS(TAG_BITS),
                .HIST_BITS(HIST_BITS), .HW(HW)
            ) u_uhash (
                .pc(update_pc[i]), .ghr(ghr_used[i]),
                .idx(u_idx[i]), .tag(u_tag[i])
            );

            assign pred_hit[i] = lookup_valid[i]
                && tbl_q[l_idx[i]].valid
                && (tbl_q[l_idx[i]].tag == l_tag[i]);
            assign pred_taken[i] = pred_hit[i]
                && (tbl_q[l_idx[i]].uncond || tbl_q[l_idx[i]].ctr[1]);
            assign pred_target[i] = pred_taken[i]
                ? tbl_q[l_idx[i]].target
                : lookup_pc[i] + 32'd4;
        end
    endgenerate

    // Same-index updates compose in slot order.
    always_comb begin
        bp_entry_t e;
        logic      tk;
        e  = '0;
        tk = 1'b0;
        tbl_d = tbl_q;
        for (int s = 0; s < WIDTH; s++) begin
            if (update_valid[s]) begin
                tk = update_taken[s] | update_uncond[s];
                e  = tbl_d[u_idx[s]];
                if (e.valid && e.tag == u_tag[s])
                    e.ctr = ctr_step(e.ctr, tk);
                else
                    e.ctr = tk ? 2'd2 : 2'd1;
                e.valid  = 1'b1;
                e.tag    = u_tag[s];
                e.target = update_target[s];
                e.uncond = update_uncond[s];
                tbl_d[u_idx[s]] = e;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < ENTRIES; k++) begin
                tbl_q[k] <= '{valid: 1'b0, tag: '0, target: '0,
                              uncond: 1'b0, ctr: 2'd1};
            end
            ghr_q <= '0;
        end else begin
            tbl_q <= tbl_d;
            ghr_q <= ghr_next;
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench: a bimodal and a gshare predictor share
// stimulus; a negedge monitor checks queued lookup results.
module tb_branch_target_predictor;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]       lookup_valid, update_valid;
    logic [1:0]       update_taken, update_uncond;
    logic [1:0][31:0] lookup_pc, update_pc, update_target;
    logic [1:0]       a_hit, a_taken, b_hit, b_taken;
    logic [1:0][31:0] a_tgt, b_tgt;

    branch_target_predictor #(.WIDTH(2)) u_a (
        .clock(clock), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_hit(a_hit), .pred_taken(a_taken), .pred_target(a_tgt),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_uncond(update_uncond),
        .update_target(update_target)
    );

    branch_target_predictor #(.WIDTH(2), .HIST_BITS(4)) u_b (
        .clock(clock), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .pred_hit(b_hit), .pred_taken(b_taken), .pred_target(b_tgt),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_taken(update_taken), .update_uncond(update_uncond),
        .update_target(update_target)
    );

    typedef struct {
        int          dut;
        int          slot;
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        string       name;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    task automatic cyc();
        @(posedge clock);
        #1;
        lookup_valid  = '0;
        lookup_pc     = '0;
        update_valid  = '0;
        update_pc     = '0;
        update_taken  = '0;
        update_uncond = '0;
        update_target = '0;
    endtask

    task automatic upd(input int s, input logic [31:0] pc,
                       input logic t, input logic u,
                       input logic [31:0] tg);
        update_valid[s]  = 1'b1;
        update_pc[s]     = pc;
        update_taken[s]  = t;
        update_uncond[s] = u;
        update_target[s] = tg;
    endtask

    task automatic look(input int s, input logic [31:0] pc);
        lookup_valid[s] = 1'b1;
        lookup_pc[s]    = pc;
    endtask

    task automatic want(input int d, input int s, input logic h,
                        input logic t, input logic [31:0] g,
                        input string n);
        exp_t e;
        e.dut = d; e.slot = s; e.hit = h;
        e.taken = t; e.tgt = g; e.name = n;
        q.push_back(e);
    endtask

    always @(negedge clock) begin
        exp_t e;
        logic h, t;
        logic [31:0] g;
        while (q.size() > 0 && lookup_valid[q[0].slot]) begin
            e = q.pop_front();
            h = (e.dut == 0) ? a_hit[e.slot]   : b_hit[e.slot];
            t = (e.dut == 0) ? a_taken[e.slot] : b_taken[e.slot];
            g = (e.dut == 0) ? a_tgt[e.slot]   : b_tgt[e.slot];
            checks++;
            if (h !== e.hit || t !== e.taken || g !== e.tgt) begin
                errors++;
                $display("FAIL %s: hit/taken/target=%0b/%0b/%h expected %0b/%0b/%h",
                         e.name, h, t, g, e.hit, e.taken, e.tgt);
            end
        end
    end

    initial begin
        lookup_valid = '0; lookup_pc = '0;
        update_valid = '0; update_pc = '0; update_taken = '0;
        update_uncond = '0; update_target = '0;
        #23 reset = 1'b1;

        // bimodal training and counter behaviour
        cyc(); look(0, 32'h100); want(0, 0, 0, 0, 32'h104, "reset_miss");
        look(1, 32'hFFFF_FFFC); want(0, 1, 0, 0, 32'h0, "wrap_pc4");
        cyc(); upd(0, 32'h100, 1, 0, 32'h200);
        cyc(); look(0, 32'h100); want(0, 0, 1, 1, 32'h200, "alloc_taken");
        look(1, 32'h500); want(0, 1, 0, 0, 32'h504, "tag_mismatch");
        upd(0, 32'h100, 0, 0, 32'h200);
        cyc(); look(0, 32'h100); want(0, 0, 1, 0, 32'h104, "ctr_1");
        upd(0, 32'h100, 0, 0, 32'h200);
        cyc(); look(0, 32'h100); want(0, 0, 1, 0, 32'h104, "ctr_0");
        upd(0, 32'h100, 0, 0, 32'h200);
        cyc(); look(0, 32'h100); want(0, 0, 1, 0, 32'h104, "ctr_sat0");
        upd(0, 32'h100, 1, 0, 32'h200);
        cyc(); look(0, 32'h100); want(0, 0, 1, 0, 32'h104, "ctr_up1");
        upd(0, 32'h100, 1, 0, 32'h200);
        cyc(); look(0, 32'h100); want(0, 0, 1, 1, 32'h200, "ctr_up2");
        upd(0, 32'h500, 0, 0, 32'h900);
        cyc(); look(0, 32'h500); want(0, 0, 1, 0, 32'h504, "realloc_nt");
        look(1, 32'h100); want(0, 1, 0, 0, 32'h104, "evicted");
        upd(0, 32'h1104, 1, 0, 32'h250);
        upd(1, 32'h1104, 1, 0, 32'h300);
        cyc(); look(0, 32'h1104); want(0, 0, 1, 1, 32'h300, "dual_slot");
        upd(0, 32'h1104, 0, 0, 32'h300);
        cyc(); look(0, 32'h1104); want(0, 0, 1, 1, 32'h300, "dual_ctr3");
        look(1, 32'h40); want(0, 1, 0, 0, 32'h44, "no_bypass");
        upd(0, 32'h40, 0, 0, 32'h80);
        cyc(); look(0, 32'h40); want(0, 0, 1, 0, 32'h44, "cond_nt");
        upd(0, 32'h40, 0, 0, 32'h80);
        cyc(); upd(0, 32'h40, 1, 1, 32'h80);
        cyc(); look(0, 32'h40); want(0, 0, 1, 1, 32'h80, "uncond_low_ctr");

        // asynchronous reset mid-cycle
        cyc(); upd(0, 32'h1104, 1, 0, 32'h700);
        look(0, 32'h1104); want(0, 0, 0, 0, 32'h1108, "rst_a");
        look(1, 32'h40); want(1, 1, 0, 0, 32'h44, "rst_b");
        #2 reset = 1'b0;
        cyc(); #2 reset = 1'b1;

        // gshare history and same-cycle chaining
        cyc(); look(0, 32'h1104); want(0, 0, 0, 0, 32'h1108, "rst_discard");
        upd(0, 32'h10C, 1, 0, 32'h3C0);
        upd(1, 32'h180, 1, 0, 32'h280);
        cyc(); upd(0, 32'h40, 1, 1, 32'h80);
        cyc(); look(0, 32'h100);
        want(1, 0, 1, 1, 32'h3C0, "gs_idx3");
        want(0, 0, 0, 0, 32'h104, "bi_idx0");
        look(1, 32'h180);
        want(1, 1, 0, 0, 32'h184, "gs_miss");
        want(0, 1, 1, 1, 32'h280, "bi_hit");
        cyc(); look(0, 32'h40);
        want(1, 0, 1, 1, 32'h80, "gs_jal");
        want(0, 0, 1, 1, 32'h80, "bi_jal");
        look(1, 32'h188);
        want(1, 1, 1, 1, 32'h280, "gs_chain");
        want(0, 1, 0, 0, 32'h18C, "bi_188");
        cyc();
        cyc();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
